// File: rtl/int_ctrl.sv
// int_ctrl: six-source level/edge interrupt controller feeding CP0 HWInt
module int_ctrl #(
  parameter int NSRC   = 6,
  parameter int LOST_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic            sel,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] hw_int
);
  logic [NSRC-1:0]   src_q, src_d;
  logic [NSRC-1:0]   pend_q, pend_d;
  logic [NSRC-1:0]   mask_q, mask_d;
  logic [NSRC-1:0]   mode_q, mode_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              wr;
  logic              overrun;
  logic [NSRC-1:0]   clr;
  logic [NSRC-1:0]   rise;
  logic [NSRC-1:0]   act;
  logic [2:0]        idx;
  // Next-state: a mode flip on a bit zeroes that pend bit, and a new edge beats a same-cycle clear
  always_comb begin
    wr      = sel & we;
    clr     = (wr && addr == 3'd3) ? wdata[NSRC-1:0] : '0;
    rise    = irq_src & ~src_q;
    src_d   = irq_src;
    mask_d  = (wr && addr == 3'd1) ? wdata[NSRC-1:0] : mask_q;
    mode_d  = (wr && addr == 3'd2) ? wdata[NSRC-1:0] : mode_q;
    pend_d  = ((mode_q & ((pend_q & ~clr) | rise)) | (~mode_q & irq_src)) & ~(mode_q ^ mode_d);
    overrun = |(rise & pend_q & ~clr & mode_q);
    lost_d  = (wr && addr == 3'd5) ? '0 : (overrun && !(&lost_q)) ? lost_q + 1'b1 : lost_q;
  end
  // Lowest-numbered enabled pending source wins the ID register
  always_comb begin
    act = pend_q & mask_q;
    idx = '0;
    for (int k = NSRC - 1; k >= 0; k--)
      if (act[k]) idx = 3'(k);
  end
  // Register read mux, purely combinational on addr
  always_comb begin
    rdata = '0;
    case (addr)
      3'd0: rdata = {{(32-NSRC){1'b0}}, pend_q};
      3'd1: rdata = {{(32-NSRC){1'b0}}, mask_q};
      3'd2: rdata = {{(32-NSRC){1'b0}}, mode_q};
      3'd4: rdata = {28'b0, |act, idx};
      3'd5: rdata = {{(32-LOST_W){1'b0}}, lost_q};
      default: rdata = '0;
    endcase
  end
  // State registers, all cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
      lost_q <= '0;
    end else begin
      src_q  <= src_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      lost_q <= lost_d;
    end
  end
  assign hw_int = pend_q & mask_q;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed stimulus with a cycle-level reference model and literal spot checks
module tb_int_ctrl;
  logic        clk = 0;
  logic        reset = 1;
  logic [5:0]  irq_src = 0;
  logic        sel = 0;
  logic        we = 0;
  logic [2:0]  addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  int checks = 0;
  int errors = 0;
  bit run = 0;

  int_ctrl dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .hw_int(hw_int)
  );

  always #5 clk = ~clk;

  // reference model state
  bit [5:0] m_pend, m_mask, m_mode, m_prev, np, m_clr;
  int m_lost;
  bit bump, m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    bit [5:0] e;
    e = m_pend & m_mask;
    case (a)
      3'd0: return {26'b0, m_pend};
      3'd1: return {26'b0, m_mask};
      3'd2: return {26'b0, m_mode};
      3'd4: begin
        for (int i = 0; i < 6; i++) if (e[i]) return 32'h8 | i;
        return 0;
      end
      3'd5: return m_lost;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0; m_lost = 0;
    end else begin
      m_wr = sel && we;
      m_clr = (m_wr && addr == 3) ? wdata[5:0] : 6'h0;
      bump = 0;
      for (int i = 0; i < 6; i++) begin
        if (m_mode[i]) begin
          if (irq_src[i] && !m_prev[i] && m_pend[i] && !m_clr[i]) bump = 1;
          np[i] = (irq_src[i] && !m_prev[i]) || (m_pend[i] && !m_clr[i]);
        end else np[i] = irq_src[i];
      end
      if (m_wr && addr == 2) begin
        for (int i = 0; i < 6; i++) if (wdata[i] != m_mode[i]) np[i] = 0;
        m_mode = wdata[5:0];
      end
      if (m_wr && addr == 1) m_mask = wdata[5:0];
      if (m_wr && addr == 5) m_lost = 0;
      else if (bump && m_lost < 255) m_lost++;
      m_pend = np;
      m_prev = irq_src;
    end
  end

  always @(negedge clk) if (run) begin
    chk("model_hw_int", {26'b0, hw_int}, {26'b0, m_pend & m_mask});
    chk("model_rdata", rdata, exp_rd(addr));
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    sel = 1; we = 1; addr = a; wdata = d;
    tick();
    sel = 0; we = 0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    addr = a; #1;
    chk(name, rdata, exp);
  endtask

  initial begin
    tick(); tick();
    reset = 0;
    run = 1;
    chk("reset_hw_int", {26'b0, hw_int}, 0);
    rd(0, 0, "reset_stat");
    rd(5, 0, "reset_lost");
    // level pass-through
    wr(1, 32'h3F);
    irq_src = 6'h04; tick();
    chk("level_hw_on", {26'b0, hw_int}, 32'h4);
    rd(4, 32'hA, "level_id");
    tick(); tick();
    irq_src = 0; tick();
    chk("level_hw_off", {26'b0, hw_int}, 0);
    // edge latch and clear
    wr(2, 32'h01);
    wr(1, 32'h01);
    irq_src = 6'h01; tick();
    irq_src = 0; tick();
    chk("edge_held", {26'b0, hw_int}, 32'h1);
    tick(); tick(); tick();
    chk("edge_still_held", {26'b0, hw_int}, 32'h1);
    wr(3, 32'h01);
    chk("edge_cleared", {26'b0, hw_int}, 0);
    // set beats clear
    irq_src = 6'h01; tick();
    irq_src = 0; tick();
    sel = 1; we = 1; addr = 3; wdata = 32'h01; irq_src = 6'h01;
    tick();
    sel = 0; we = 0;
    chk("set_beats_clr", {26'b0, hw_int}, 32'h1);
    rd(5, 0, "set_beats_clr_lost");
    irq_src = 0;
    wr(3, 32'h01);
    // lost-edge counting on bit 3
    wr(2, 32'h09);
    wr(1, 32'h08);
    for (int n = 0; n < 300; n++) begin
      irq_src = 6'h08; tick();
      irq_src = 0; tick();
    end
    rd(5, 255, "lost_saturated");
    wr(5, 0);
    rd(5, 0, "lost_cleared");
    // mask and priority
    wr(2, 0);
    irq_src = 6'h30; tick();
    wr(1, 32'h20);
    chk("prio_hw_int", {26'b0, hw_int}, 32'h20);
    rd(4, 32'hD, "prio_id");
    wr(1, 0);
    rd(4, 0, "masked_id");
    chk("masked_hw_int", {26'b0, hw_int}, 0);
    // reset mid-operation
    irq_src = 0;
    wr(2, 32'h08);
    wr(1, 32'h3F);
    for (int n = 0; n < 6; n++) begin
      irq_src = 6'h3F; tick();
      irq_src = 6'h37; tick();
    end
    rd(5, 5, "pre_reset_lost");
    chk("pre_reset_hw_int", {26'b0, hw_int}, 32'h3F);
    reset = 1; tick();
    reset = 0;
    chk("post_reset_hw_int", {26'b0, hw_int}, 0);
    for (int a = 0; a < 8; a++) rd(3'(a), 0, "post_reset_rdata");
    tick(); tick();
    chk("post_reset_level_masked", {26'b0, hw_int}, 0);
    rd(0, 32'h37, "post_reset_level_pend");
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
